// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - CPU bus wait-state and read-data return engine
// Optional fabric timeout and late-response dropping enabled by BUS_TIMEOUT_EN.

module cpu_bus_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_is_read,
    input  logic [1:0]  req_addr_lo,
    input  logic [2:0]  req_addr_type,
    input  logic [7:0]  int_rdata,
    input  logic        resp_valid,
    input  logic [31:0] resp_rdata,
    input  logic        resp_err,
    input  logic        cycle_end,
    output logic        cpu_ready,
    output logic [7:0]  cpu_d,
    output logic        cpu_d_oe,
    output logic        busy,
    output logic        overlap_err,
    output logic        timeout_flag
);

    // Address type encoding shared with the bus front end decoder
    localparam logic [2:0] ADDR_TYPE_NOT_OP          = 3'd0;
    localparam logic [2:0] ADDR_TYPE_AXI             = 3'd1;
    localparam logic [2:0] ADDR_TYPE_INTERNAL_ROM    = 3'd2;
    localparam logic [2:0] ADDR_TYPE_INTERNAL_RAM    = 3'd3;
    localparam logic [2:0] ADDR_TYPE_INTERNAL_BUTTON = 3'd4;

    typedef enum logic [1:0] {IDLE, WAIT_INT, WAIT_AXI, HOLD} state_t;

    state_t     state;
    logic       is_read_q;
    logic [1:0] addr_lo_q;
    logic       drop_resp;
    logic       timeout_hit;
    logic       resp_ok;

`ifdef BUS_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic [1:0]  drop_cnt;

    assign drop_resp   = resp_valid && (drop_cnt != 2'd0);
    assign timeout_hit = (state == WAIT_AXI) && !resp_ok &&
                         (to_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt       <= 16'd0;
            drop_cnt     <= 2'd0;
            timeout_flag <= 1'b0;
        end else begin
            to_cnt <= (state == WAIT_AXI && !timeout_hit) ? to_cnt + 16'd1 : 16'd0;
            if (timeout_hit)
                timeout_flag <= 1'b1;
            // A drop and a new timeout in the same cycle cancel out
            if (timeout_hit && !drop_resp && drop_cnt != 2'd3)
                drop_cnt <= drop_cnt + 2'd1;
            else if (drop_resp && !timeout_hit)
                drop_cnt <= drop_cnt - 2'd1;
        end
    end
`else
    assign drop_resp    = 1'b0;
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    assign resp_ok = resp_valid && !drop_resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            is_read_q   <= 1'b0;
            addr_lo_q   <= 2'd0;
            cpu_ready   <= 1'b1;
            cpu_d       <= 8'h00;
            cpu_d_oe    <= 1'b0;
            busy        <= 1'b0;
            overlap_err <= 1'b0;
        end else begin
            if (req_valid && state != IDLE)
                overlap_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_valid && req_addr_type != ADDR_TYPE_NOT_OP) begin
                        is_read_q <= req_is_read;
                        addr_lo_q <= req_addr_lo;
                        busy      <= 1'b1;
                        if (req_addr_type == ADDR_TYPE_AXI) begin
                            state     <= WAIT_AXI;
                            cpu_ready <= 1'b0;
                        end else if (req_is_read &&
                                     (req_addr_type == ADDR_TYPE_INTERNAL_ROM ||
                                      req_addr_type == ADDR_TYPE_INTERNAL_RAM ||
                                      req_addr_type == ADDR_TYPE_INTERNAL_BUTTON)) begin
                            state     <= WAIT_INT;
                            cpu_ready <= 1'b0;
                        end else begin
                            // Internal writes complete at once; other reads float high
                            state    <= HOLD;
                            cpu_d_oe <= req_is_read;
                            if (req_is_read)
                                cpu_d <= 8'hFF;
                        end
                    end
                end
                WAIT_INT: begin
                    state     <= HOLD;
                    cpu_d     <= int_rdata;
                    cpu_ready <= 1'b1;
                    cpu_d_oe  <= is_read_q;
                end
                WAIT_AXI: begin
                    if (resp_ok || timeout_hit) begin
                        state     <= HOLD;
                        cpu_ready <= 1'b1;
                        cpu_d_oe  <= is_read_q;
                        if (is_read_q)
                            cpu_d <= (resp_ok && !resp_err) ?
                                     resp_rdata[{addr_lo_q, 3'b000} +: 8] : 8'hFF;
                    end
                end
                HOLD: begin
                    if (cycle_end) begin
                        state    <= IDLE;
                        cpu_d_oe <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_bus_responder.md
# cpu_bus_responder

Return-path engine between the AXI/internal fabric and the 8-bit CPU bus, for both the Z80 and 8088 builds. It takes each decoded CPU cycle (address type, read/write, low address bits) from the bus front end and holds the CPU in wait states by driving READY low until the target completes. For reads it selects the correct byte lane of the 32-bit response and drives it onto the CPU data bus until the CPU ends the cycle. It also reports overlapping requests and, optionally, fabric timeouts.

## Interface
- TIMEOUT_CYCLES, 1023, max cycles in WAIT_AXI before forced completion (used only with BUS_TIMEOUT_EN); 1..65535
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  one-cycle pulse: new CPU cycle decoded
- req_is_read  in  1  1 = read, 0 = write
- req_addr_lo  in  2  A32[1:0] of the request, selects the byte lane
- req_addr_type  in  3  ADDR_TYPE_* encoding from addr_map.svh
- int_rdata  in  8  internal ROM/RAM/button read data; valid the cycle after req_valid
- resp_valid  in  1  one-cycle pulse: AXI read or write completion
- resp_rdata  in  32  AXI read data; valid with resp_valid
- resp_err  in  1  AXI RRESP/BRESP not OKAY; valid with resp_valid
- cycle_end  in  1  CPU has deasserted RD/WR
- cpu_ready  out  1  CPU READY; 0 = insert wait state
- cpu_d  out  8  read data to the CPU
- cpu_d_oe  out  1  CPU data bus output enable
- busy  out  1  state != IDLE
- overlap_err  out  1  sticky: req_valid arrived while not IDLE
- timeout_flag  out  1  sticky: timeout occurred (constant 0 without BUS_TIMEOUT_EN)

## Operation
- States: IDLE, WAIT_INT, WAIT_AXI, HOLD. All outputs are registered.
- Reset values: state IDLE, cpu_ready=1, cpu_d=8'h00, cpu_d_oe=0, busy=0, overlap_err=0, timeout_flag=0. Drop counter and timeout counter are 0.
- IDLE, on req_valid, request fields are latched and the next state is chosen by type:
  - AXI: WAIT_AXI.
  - INTERNAL_ROM, INTERNAL_RAM or INTERNAL_BUTTON read: WAIT_INT.
  - Any internal write (RAM, LED, GPIO): HOLD.
  - UNKNOWN: HOLD. A read returns 8'hFF.
  - NOT_OP: stay in IDLE.
- WAIT_INT: latch int_rdata and go to HOLD. Takes exactly one cycle.
- WAIT_AXI, on resp_valid with drop counter = 0, go to HOLD:
  - Read data = resp_rdata[8*addr_lo +: 8].
  - If resp_err, read data = 8'hFF.
  - Writes latch no data.
- HOLD: cpu_ready=1 and cpu_d_oe=latched is_read. On cycle_end, go to IDLE; cpu_d_oe clears on that transition.
- cycle_end is ignored outside HOLD. The CPU cannot end a cycle while READY is low.
- resp_valid in IDLE, WAIT_INT or HOLD is discarded. Stray responses never alter cpu_d.
- req_valid outside IDLE: the request is dropped and overlap_err is set. overlap_err clears only on rst.
- cpu_ready = 0 in WAIT_INT and WAIT_AXI, 1 otherwise.
- rst mid-transaction returns to IDLE immediately and clears the drop counter. Any later resp_valid is treated as stray.

## Timing
- req_valid sampled at edge N: cpu_ready=0 from N+1.
- Internal read: int_rdata sampled at N+1. cpu_ready=1 and cpu_d valid from N+2.
- Internal or UNKNOWN write: state HOLD from N+1; cpu_ready never drops.
- AXI: resp_valid sampled at edge M: cpu_ready=1 and cpu_d valid from M+1.
- cycle_end sampled at edge K: cpu_d_oe=0 and busy=0 from K+1. A new req_valid is accepted from K+1.
- Back-to-back operation: a req_valid in the same cycle as cycle_end in HOLD is an overlap and is dropped.

## Configuration
- BUS_TIMEOUT_EN defined:
  - A 16-bit counter runs in WAIT_AXI and clears on entry.
  - When it reaches TIMEOUT_CYCLES without a resp_valid: go to HOLD, read data = 8'hFF, set timeout_flag, increment the 2-bit drop counter (saturating at 3).
  - Each later resp_valid with drop counter > 0 is discarded, in any state, and decrements the counter.
- BUS_TIMEOUT_EN undefined: no counter and no drop counter. WAIT_AXI waits forever; timeout_flag is tied to 0.

## Test plan
- AXI read, addr_lo=2, resp_rdata=32'hDDCCBBAA, resp 5 cycles later -> cpu_ready low for 5 cycles, then cpu_d=8'hCC with cpu_d_oe=1 until cycle_end; IDLE one cycle after.
- INTERNAL_ROM read, int_rdata=8'h3E -> cpu_ready=0 for exactly one cycle, cpu_d=8'h3E.
- AXI read with resp_err=1 -> cpu_d=8'hFF. AXI write -> cpu_d_oe stays 0 throughout.
- Stray resp_valid in IDLE, then req_valid during WAIT_AXI -> cpu_d unchanged, overlap_err=1, original response completes normally.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response -> HOLD after 8 wait cycles, cpu_d=8'hFF, timeout_flag=1. Late resp 32'h11 during the next AXI read is discarded; the following resp 32'h22 (addr_lo=0) returns 8'h22.
- rst asserted in WAIT_AXI -> next cycle cpu_ready=1 and busy=0; the following resp_valid is ignored.
